// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with registered sync/blank flags (the timing_if signals).
// Defining VGA_TIMING_FRAME_TICK_EN adds a one-cycle frame_tick output at (0,0).
module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FRONT  = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BACK   = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FRONT  = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 29
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
`ifdef VGA_TIMING_FRAME_TICK_EN
    output logic        frame_tick,
`endif
    output logic        vblnk
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 2048) begin : g_h_total_check
        $error("vga_timing: H_TOTAL does not fit the 11-bit hcount");
    end
    if (V_TOTAL > 2048) begin : g_v_total_check
        $error("vga_timing: V_TOTAL does not fit the 11-bit vcount");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Decode bounds are 12 bits wide so a sync end equal to 2048 does not wrap to 0.
    localparam logic [11:0] H_BLNK_START = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_BLNK_START = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic [11:0] h_nxt_ext, v_nxt_ext;

    // Flags decode the next position so they line up with the counters they describe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 11'd1;
        end
        h_nxt_ext = {1'b0, hcount_d};
        v_nxt_ext = {1'b0, vcount_d};
        hblnk_d   = (h_nxt_ext >= H_BLNK_START);
        hsync_d   = (h_nxt_ext >= H_SYNC_START) && (h_nxt_ext < H_SYNC_END);
        vblnk_d   = (v_nxt_ext >= V_BLNK_START);
        vsync_d   = (v_nxt_ext >= V_SYNC_START) && (v_nxt_ext < V_SYNC_END);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign hblnk  = hblnk_q;
    assign vblnk  = vblnk_q;

`ifdef VGA_TIMING_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    // Reset forces (0,0) without a tick; only the counting wrap produces one.
    always_comb begin
        frame_tick_d = (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default geometry for line-level timing, a shrunken
// geometry instance for frame-level timing, wrap corner and mid-frame reset.
module tb_vga_timing;

    // Small geometry: H_TOTAL = 15, V_TOTAL = 12, frame = 180 clocks.
    localparam int SH_TOTAL = 15;
    localparam int SV_TOTAL = 12;
    localparam int S_FRAME  = SH_TOTAL * SV_TOTAL;
    localparam int H_TOTAL  = 1344;
    localparam int WINDOW   = 3 * H_TOTAL + 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hc, vc, s_hc, s_vc;
    logic        hs, vs, hb, vb, s_hs, s_vs, s_hb, s_vb;
`ifdef VGA_TIMING_FRAME_TICK_EN
    logic        ft, s_ft;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_timing dut (
        .clk(clk), .rst(rst), .hcount(hc), .vcount(vc),
        .hsync(hs), .vsync(vs), .hblnk(hb),
`ifdef VGA_TIMING_FRAME_TICK_EN
        .frame_tick(ft),
`endif
        .vblnk(vb)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .clk(clk), .rst(rst), .hcount(s_hc), .vcount(s_vc),
        .hsync(s_hs), .vsync(s_vs), .hblnk(s_hb),
`ifdef VGA_TIMING_FRAME_TICK_EN
        .frame_tick(s_ft),
`endif
        .vblnk(s_vb)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hc"}, 32'(hc), 0);
        check({tag, "_vc"}, 32'(vc), 0);
        check({tag, "_flags"}, {28'd0, hs, vs, hb, vb}, 0);
        check({tag, "_s_hc"}, 32'(s_hc), 0);
        check({tag, "_s_vc"}, 32'(s_vc), 0);
        check({tag, "_s_flags"}, {28'd0, s_hs, s_vs, s_hb, s_vb}, 0);
`ifdef VGA_TIMING_FRAME_TICK_EN
        check({tag, "_ticks"}, {30'd0, ft, s_ft}, 0);
`endif
    endtask

    // Called with the first post-reset sample (k = 1) already taken.
    task automatic run_window(input string tag);
        int last_h0 = -1, line_per = -1;
        int hb_rise_h = -1, hb_rise_k = -1, hb_len = -1, hb_fall_h = -1;
        int hs_rise_h = -1, hs_rise_k = -1, hs_len = -1, hs_fall_h = -1;
        int hb_1023 = -1, hb_1024 = -1, vflag_seen = 0;
        int wraps = 0, last_f0 = -1, frame_lines = -1;
        int vb_rise_v = -1, vb_rise_h = -1, vb_rise_k = -1, vb_len = -1, vb_fall_v = -1, vb_fall_h = -1;
        int vs_rise_v = -1, vs_rise_h = -1, vs_rise_k = -1, vs_len = -1, vs_fall_v = -1;
        int corner_n = 0;
        logic p_hb, p_hs, p_vb, p_vs;
        logic [10:0] p_shc, p_svc;
`ifdef VGA_TIMING_FRAME_TICK_EN
        int ticks = 0, tick_off = 0, tick_gap = -1, first_tick = -1, last_tick = -1, big_ticks = 0;
        logic p_ft = 1'b0;
`endif
        p_hb = hb; p_hs = hs; p_vb = s_vb; p_vs = s_vs; p_shc = s_hc; p_svc = s_vc;
        for (int k = 2; k <= WINDOW; k++) begin
            tick();
            if (hc == 0) begin
                if (last_h0 >= 0) line_per = k - last_h0;
                last_h0 = k;
            end
            if (hb && !p_hb) begin hb_rise_h = hc; hb_rise_k = k; end
            if (!hb && p_hb && hb_rise_k >= 0) begin hb_len = k - hb_rise_k; hb_fall_h = hc; end
            if (hs && !p_hs) begin hs_rise_h = hc; hs_rise_k = k; end
            if (!hs && p_hs && hs_rise_k >= 0) begin hs_len = k - hs_rise_k; hs_fall_h = hc; end
            if (hc == 1023) hb_1023 = hb;
            if (hc == 1024) hb_1024 = hb;
            if (vb || vs) vflag_seen = 1;

            if (s_hc == 0) begin
                wraps++;
                if (s_vc == 0) begin
                    if (last_f0 >= 0) frame_lines = wraps - last_f0;
                    last_f0 = wraps;
                end
            end
            if (s_vb && !p_vb) begin vb_rise_v = s_vc; vb_rise_h = s_hc; vb_rise_k = k; end
            if (!s_vb && p_vb && vb_rise_k >= 0) begin
                vb_len = k - vb_rise_k; vb_fall_v = s_vc; vb_fall_h = s_hc;
            end
            if (s_vs && !p_vs) begin vs_rise_v = s_vc; vs_rise_h = s_hc; vs_rise_k = k; end
            if (!s_vs && p_vs && vs_rise_k >= 0) begin vs_len = k - vs_rise_k; vs_fall_v = s_vc; end
            if (p_shc == 14 && p_svc == 11) begin
                corner_n++;
                check({tag, "_corner_pos"}, {5'd0, s_hc, 5'd0, s_vc}, 0);
                check({tag, "_corner_flags"}, {28'd0, s_hs, s_vs, s_hb, s_vb}, 0);
            end
`ifdef VGA_TIMING_FRAME_TICK_EN
            if (s_ft) begin
                ticks++;
                if (s_hc != 0 || s_vc != 0 || p_ft) tick_off++;
                if (first_tick < 0) first_tick = k;
                if (last_tick >= 0) tick_gap = k - last_tick;
                last_tick = k;
            end
            if (ft) big_ticks++;
            p_ft = s_ft;
`endif
            p_hb = hb; p_hs = hs; p_vb = s_vb; p_vs = s_vs; p_shc = s_hc; p_svc = s_vc;
        end

        check({tag, "_line_period"}, line_per, H_TOTAL);
        check({tag, "_hblnk_rise_h"}, hb_rise_h, 1024);
        check({tag, "_hblnk_len"}, hb_len, 320);
        check({tag, "_hblnk_fall_h"}, hb_fall_h, 0);
        check({tag, "_hblnk_at_1023"}, hb_1023, 0);
        check({tag, "_hblnk_at_1024"}, hb_1024, 1);
        check({tag, "_hsync_rise_h"}, hs_rise_h, 1048);
        check({tag, "_hsync_len"}, hs_len, 136);
        check({tag, "_hsync_fall_h"}, hs_fall_h, 1184);
        check({tag, "_big_vflags"}, vflag_seen, 0);
        check({tag, "_end_hc"}, 32'(hc), WINDOW % H_TOTAL);
        check({tag, "_end_vc"}, 32'(vc), WINDOW / H_TOTAL);

        check({tag, "_frame_lines"}, frame_lines, SV_TOTAL);
        check({tag, "_vblnk_rise_pos"}, {vb_rise_v[15:0], vb_rise_h[15:0]}, {16'd6, 16'd0});
        check({tag, "_vblnk_len"}, vb_len, 6 * SH_TOTAL);
        check({tag, "_vblnk_fall_pos"}, {vb_fall_v[15:0], vb_fall_h[15:0]}, 0);
        check({tag, "_vsync_rise_pos"}, {vs_rise_v[15:0], vs_rise_h[15:0]}, {16'd7, 16'd0});
        check({tag, "_vsync_len"}, vs_len, 2 * SH_TOTAL);
        check({tag, "_vsync_fall_v"}, vs_fall_v, 9);
        check({tag, "_corner_seen"}, 32'(corner_n > 0), 1);
        check({tag, "_s_end_hc"}, 32'(s_hc), WINDOW % SH_TOTAL);
        check({tag, "_s_end_vc"}, 32'(s_vc), (WINDOW / SH_TOTAL) % SV_TOTAL);
`ifdef VGA_TIMING_FRAME_TICK_EN
        check({tag, "_tick_count"}, ticks, WINDOW / S_FRAME);
        check({tag, "_tick_off"}, tick_off, 0);
        check({tag, "_tick_first"}, first_tick, S_FRAME);
        check({tag, "_tick_gap"}, tick_gap, S_FRAME);
        check({tag, "_big_ticks"}, big_ticks, 0);
`endif
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("reset");
        end

        rst = 1'b0;
        tick();
        check("start_hc", 32'(hc), 1);
        check("start_vc", 32'(vc), 0);
        check("start_hblnk_hsync", {30'd0, hb, hs}, 0);
        check("start_s_pos", {5'd0, s_hc, 5'd0, s_vc}, {16'd1, 16'd0});
        run_window("run1");

        // Reset while the small instance sits inside vsync/vblank.
        waited = 0;
        while (!(s_hc == 5 && s_vc == 8) && waited < 400) begin
            tick();
            waited++;
        end
        check("mid_trigger_found", 32'(waited < 400), 1);
        check("mid_pre_flags", {30'd0, s_vs, s_vb}, 3);
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        tick();
        check("restart_pos", {5'd0, hc, 5'd0, vc}, {16'd1, 16'd0});
        check("restart_s_pos", {5'd0, s_hc, 5'd0, s_vc}, {16'd1, 16'd0});
        run_window("run2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
